spu_stall_ctrl: RTL and testbench

Central pipeline stall/flush controller for the dual-issue SPU pipeline. Collects per-stage stall requests, multi-cycle hold requests from long-latency units and flush requests. Produces the 13-bit stall vector consumed by every pipeline register, including the MEM/WB register. Per that vector's rule, a stage is held while its successor is released, so a bubble is inserted downstream of the highest stalled stage.

---
 rtl/spu_stall_ctrl.sv | 115 +++++++++++
 tb/tb_spu_stall_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spu_stall_ctrl.sv
// Stall/flush controller: combinational prefix stall vector from stage requests and multi-cycle holds; FSM IDLE/HOLD/FLUSH.
// Optional STALL_PERF_CNT_EN adds a 32-bit count of cycles with stall[0] set; otherwise stall_cycles is tied to 0.
module spu_stall_ctrl #(
    parameter int N_STAGES     = 13,
    parameter int CNT_W        = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [0:N_STAGES-1] stall_req,
    input  logic                mc_start,
    input  logic [3:0]          mc_stage,
    input  logic [CNT_W-1:0]    mc_cycles,
    input  logic                flush_req,
    output logic [0:N_STAGES-1] stall,
    output logic                flush,
    output logic                busy,
    output logic [31:0]         stall_cycles
);

    localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCNT_W-1:0] F_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [3:0] LAST_STAGE = 4'(N_STAGES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   hcnt, hcnt_n;
    logic [FCNT_W-1:0]  fcnt, fcnt_n;
    logic [3:0]         hold_stage, hold_stage_n;
    logic [0:N_STAGES-1] src;
    logic               acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hcnt       <= '0;
            fcnt       <= '0;
            hold_stage <= '0;
        end else begin
            state      <= state_n;
            hcnt       <= hcnt_n;
            fcnt       <= fcnt_n;
            hold_stage <= hold_stage_n;
        end
    end

    always_comb begin
        state_n      = state;
        hcnt_n       = hcnt;
        fcnt_n       = fcnt;
        hold_stage_n = hold_stage;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_n = FLUSH;
                    fcnt_n  = F_RELOAD;
                end else if (mc_start && mc_cycles != '0) begin
                    state_n      = HOLD;
                    hold_stage_n = (mc_stage > LAST_STAGE) ? LAST_STAGE : mc_stage;
                    hcnt_n       = mc_cycles - CNT_W'(1);
                end
            end
            HOLD: begin
                if (flush_req) begin
                    state_n = FLUSH;
                    fcnt_n  = F_RELOAD;
                    hcnt_n  = '0;
                end else if (hcnt == '0) begin
                    state_n = IDLE;
                end else begin
                    hcnt_n = hcnt - CNT_W'(1);
                end
            end
            FLUSH: begin
                if (flush_req) begin
                    fcnt_n = F_RELOAD;
                end else if (fcnt == '0) begin
                    state_n = IDLE;
                end else begin
                    fcnt_n = fcnt - FCNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Each stage stalls if any source sits at or beyond it, giving the prefix mask.
    always_comb begin
        src   = stall_req;
        stall = '0;
        acc   = 1'b0;
        if (state == HOLD)
            src[hold_stage] = 1'b1;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            acc      = acc | src[i];
            stall[i] = acc && (state != FLUSH);
        end
    end

    assign flush = (state == FLUSH);
    assign busy  = (state != IDLE);

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall[0])
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_spu_stall_ctrl.sv
// Randomized + directed bench for spu_stall_ctrl with a queue-based scoreboard and a cycle-level behavioural model.
module tb_spu_stall_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_HOLD  = 1;
    localparam int M_FLUSH = 2;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:12] stall_req;
    logic        mc_start;
    logic [3:0]  mc_stage;
    logic [5:0]  mc_cycles;
    logic        flush_req;
    logic [0:12] stall;
    logic        flush;
    logic        busy;
    logic [31:0] stall_cycles;

    spu_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req    (stall_req),
        .mc_start     (mc_start),
        .mc_stage     (mc_stage),
        .mc_cycles    (mc_cycles),
        .flush_req    (flush_req),
        .stall        (stall),
        .flush        (flush),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:12] stall;
        logic        flush;
        logic        busy;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: mode, cycles still to spend in HOLD/FLUSH (including the current one), held stage.
    int          m_mode;
    int          m_hold_left;
    int          m_flush_left;
    int          m_hold_stage;
    logic [31:0] m_count;

    function automatic logic [0:12] model_stall(input logic [0:12] req, input int mode, input int hs);
        logic [0:12] v;
        int k;
        k = -1;
        v = '0;
        if (mode == M_FLUSH) return v;
        for (int i = 0; i < 13; i++)
            if (req[i]) k = i;
        if (mode == M_HOLD && hs > k) k = hs;
        for (int i = 0; i < 13; i++)
            v[i] = (i <= k);
        return v;
    endfunction

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_hold_left  = 0;
        m_flush_left = 0;
        m_hold_stage = 0;
        m_count      = 32'd0;
    endtask

    task automatic cyc(input logic r, input logic [0:12] req, input logic ms,
                       input logic [3:0] mst, input logic [5:0] mcy, input logic fr);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall_req = req; mc_start = ms; mc_stage = mst; mc_cycles = mcy; flush_req = fr;
        e.stall = model_stall(req, m_mode, m_hold_stage);
        e.flush = (m_mode == M_FLUSH);
        e.busy  = (m_mode != M_IDLE);
`ifdef STALL_PERF_CNT_EN
        e.sc    = m_count;
`else
        e.sc    = 32'd0;
`endif
        exp_q.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            if (e.stall[0]) m_count = m_count + 32'd1;
            case (m_mode)
                M_IDLE: begin
                    if (fr) begin
                        m_mode = M_FLUSH; m_flush_left = FLUSH_CYCLES;
                    end else if (ms && mcy != 0) begin
                        m_mode = M_HOLD; m_hold_left = int'(mcy);
                        m_hold_stage = (int'(mst) > 12) ? 12 : int'(mst);
                    end
                end
                M_HOLD: begin
                    if (fr) begin
                        m_mode = M_FLUSH; m_flush_left = FLUSH_CYCLES;
                    end else begin
                        m_hold_left--;
                        if (m_hold_left == 0) m_mode = M_IDLE;
                    end
                end
                default: begin
                    if (fr) begin
                        m_flush_left = FLUSH_CYCLES;
                    end else begin
                        m_flush_left--;
                        if (m_flush_left == 0) m_mode = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 4'd0, 6'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || flush !== e.flush || busy !== e.busy || stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL outputs t=%0t: got stall=%b flush=%b busy=%b sc=%0d, want stall=%b flush=%b busy=%b sc=%0d",
                         $time, stall, flush, busy, stall_cycles, e.stall, e.flush, e.busy, e.sc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:12] r;
        logic [0:12] ones;
        rst = 1'b1; stall_req = '0; mc_start = 1'b0; mc_stage = '0; mc_cycles = '0; flush_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        idle(2);
        r = '0; r[11] = 1'b1;
        cyc(1'b0, r, 1'b0, 4'd0, 6'd0, 1'b0);
        idle(2);

        cyc(1'b0, '0, 1'b1, 4'd8, 6'd3, 1'b0);
        idle(5);
        cyc(1'b0, '0, 1'b1, 4'd8, 6'd0, 1'b0);
        idle(3);

        ones = '1;
        cyc(1'b0, '0, 1'b1, 4'd8, 6'd3, 1'b0);
        idle(1);
        cyc(1'b0, '0, 1'b0, 4'd0, 6'd0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, ones, 1'b0, 4'd0, 6'd0, 1'b0);
        idle(1);

        cyc(1'b0, '0, 1'b0, 4'd0, 6'd0, 1'b1);
        cyc(1'b0, '0, 1'b0, 4'd0, 6'd0, 1'b1);
        idle(4);
        cyc(1'b0, '0, 1'b0, 4'd0, 6'd0, 1'b1);
        idle(1);
        cyc(1'b0, '0, 1'b0, 4'd0, 6'd0, 1'b1);
        idle(4);

        cyc(1'b0, '0, 1'b1, 4'd15, 6'd10, 1'b0);
        idle(3);
        cyc(1'b1, '0, 1'b0, 4'd0, 6'd0, 1'b0);
        idle(2);
        r = '0; r[3] = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b0, r, 1'b0, 4'd0, 6'd0, 1'b0);
        idle(2);

        for (int n = 0; n < 2000; n++) begin
            r = '0;
            if ($urandom_range(0, 2) != 0)
                for (int i = 0; i < 13; i++) r[i] = ($urandom_range(0, 9) == 0);
            cyc($urandom_range(0, 59) == 0, r, $urandom_range(0, 7) == 0,
                4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)), $urandom_range(0, 14) == 0);
        end
        idle(2);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
